// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//  - funct codes for the HI/LO instruction group (values from common_param.vh)
//  - FSM state encoding for the iterative datapath
//  - small decode helpers used by the top level
package muldiv_unit_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Codes that start the iterative FSM.
  function automatic logic is_md(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // Signed forms take operand magnitudes and sign-correct in FIX.
  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_step: one combinational radix-2 iteration.
//  is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//  acc_hi  : upper accumulator (partial product high / partial remainder)
//  acc_lo  : lower accumulator (multiplier bits / dividend bits -> quotient)
//  opnd    : multiplicand (mul) or divisor (div) magnitude
//  nxt_hi, nxt_lo : accumulator after this iteration
// Multiply consumes the multiplier LSB-first and shifts the product right;
// divide shifts the dividend MSB-first into the remainder and shifts the
// quotient bit into acc_lo from the bottom.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;   // add-or-skip, carry kept in bit WIDTH
  logic [WIDTH:0] shr;   // remainder shifted left with next dividend bit
  logic [WIDTH:0] diff;  // trial subtract; bit WIDTH set means borrow

  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shr  = {acc_hi, acc_lo[WIDTH-1]};
    diff = shr - {1'b0, opnd};
    if (is_div) begin
      // Remainder stays below the divisor, so it always fits WIDTH bits.
      nxt_hi = diff[WIDTH] ? shr[WIDTH-1:0] : diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for the EX stage.
// Owns the HI/LO registers; MTHI/MTLO write them in one edge, MULT/MULTU/
// DIV/DIVU run IDLE -> CALC (WIDTH edges) -> FIX -> IDLE.
// Ports:
//  CLK, RST        clock (rising), async active-high reset
//  Req, Funct      request valid and funct field from EX
//  Rdata1, Rdata2  rs / rt operands
//  Busy            op in flight, requests dropped
//  Done            one-cycle pulse when Hi/Lo carry a new result
//  Hi, Lo          architectural HI/LO
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic             is_div_q, qsign_q, rsign_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             accept, sgn, s1, s2;
  logic [WIDTH-1:0] m1, m2;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;
  assign Hi     = hi_q;
  assign Lo     = lo_q;
  assign accept = Req && !Busy;

  // Operand magnitudes; unsigned forms pass raw values.
  always_comb begin
    sgn = is_signed_op(Funct);
    s1  = sgn & Rdata1[WIDTH-1];
    s2  = sgn & Rdata2[WIDTH-1];
    m1  = s1 ? -Rdata1 : Rdata1;
    m2  = s2 ? -Rdata2 : Rdata2;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .opnd   (opnd_q),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // Sign correction applied on the FIX edge.
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = qsign_q ? -prod : prod;
    // Divide by zero: quotient forced to all ones; remainder magnitude equals
    // |dividend|, so re-applying the dividend sign returns the raw dividend.
    quo_fix  = dz_q ? '1 : (qsign_q ? -acc_lo_q : acc_lo_q);
    rem_fix  = rsign_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_md(Funct)) state_d = CALC;
      CALC:    if (cnt_q == CW'(WIDTH-1))  state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      is_div_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (Funct)
              F_MTHI: begin hi_q <= Rdata2; done_q <= 1'b1; end
              F_MTLO: begin lo_q <= Rdata2; done_q <= 1'b1; end
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                is_div_q <= is_div_op(Funct);
                opnd_q   <= is_div_op(Funct) ? m2 : m1;
                acc_lo_q <= is_div_op(Funct) ? m1 : m2;
                acc_hi_q <= '0;
                qsign_q  <= s1 ^ s2;
                rsign_q  <= s1;
                dz_q     <= is_div_op(Funct) && (Rdata2 == '0);
                cnt_q    <= '0;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc_hi_q <= nxt_hi;
          acc_lo_q <= nxt_lo;
          cnt_q    <= cnt_q + 1'b1;
        end
        FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
          cnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors, latency, boundaries,
// ignored requests, reset mid-op and back-to-back issue.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req = 1'b0;
  logic [5:0]  Funct = '0;
  logic [31:0] Rdata1 = '0, Rdata2 = '0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int n_chk = 0;
  int n_pass = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Funct(Funct),
    .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Present a request for one edge; returns #1 after that edge.
  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    Req = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
    @(posedge CLK); #1;
    Req = 1'b0;
  endtask

  task automatic op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    drive(f, a, b);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!Done && cyc < 100) begin
      @(posedge CLK); #1; cyc++;
    end
    if (!Done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Issue a mult/div, check Busy, hold of Hi/Lo, latency and result.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] ohi, olo;
    logic        changed;
    int          cyc;
    ohi = Hi; olo = Lo; changed = 1'b0; cyc = 0;
    op(f, a, b);
    chk({tag, "_busy"}, {63'd0, Busy}, 64'd1);
    while (!Done && cyc < 100) begin
      @(posedge CLK); #1; cyc++;
      if (!Done && (Hi !== ohi || Lo !== olo)) changed = 1'b1;
    end
    chk({tag, "_hold"}, {63'd0, changed}, 64'd0);
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk({tag, "_hilo"}, {Hi, Lo}, {ehi, elo});
  endtask

  initial begin
    int          cyc, hits;
    logic [31:0] ohi, olo;

    #1;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;

    // 1-3: arithmetic and boundaries
    run_md("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("div_neg",   F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_negd",  F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_md("divu_z",    F_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_md("div_z_neg", F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_md("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_md("mult_min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_md("divu_big",  F_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF);

    // 4: MTHI single-edge write, Lo untouched
    olo = Lo;
    op(F_MTHI, 32'd0, 32'h1234);
    chk("mthi_done", {63'd0, Done}, 64'd1);
    chk("mthi_busy", {63'd0, Busy}, 64'd0);
    chk("mthi_hilo", {Hi, Lo}, {32'h1234, olo});
    @(posedge CLK); #1;
    chk("mthi_pulse", {63'd0, Done}, 64'd0);

    // MTLO while busy is dropped
    op(F_MULTU, 32'd6, 32'd7);
    repeat (5) @(posedge CLK);
    olo = Lo;
    @(negedge CLK);
    drive(F_MTLO, 32'd0, 32'hDEAD);
    chk("mtlo_busy_lo", {32'd0, Lo}, {32'd0, olo});
    wait_done(cyc);
    chk("mtlo_busy_res", {Hi, Lo}, {32'd0, 32'd42});

    // 5: reset in the middle of a DIVU
    op(F_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge CLK);
    #2; RST = 1'b1; #1;
    chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
    chk("rst_mid_done", {63'd0, Done}, 64'd0);
    chk("rst_mid_hilo", {Hi, Lo}, 64'd0);
    @(negedge CLK); RST = 1'b0;
    run_md("post_rst", F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    // 6: request on the Done cycle is accepted with no gap
    op(F_MULTU, 32'd3, 32'd5);
    wait_done(cyc);
    chk("b2b_first", {Hi, Lo}, {32'd0, 32'd15});
    drive(F_DIVU, 32'd100, 32'd7);
    chk("b2b_busy", {63'd0, Busy}, 64'd1);
    wait_done(cyc);
    chk("b2b_lat", 64'(cyc), 64'd33);
    chk("b2b_res", {Hi, Lo}, {32'd2, 32'd14});

    // Unsupported funct and MFHI never start anything
    ohi = Hi; olo = Lo; hits = 0;
    op(6'h20, 32'd5, 32'd5);
    if (Done || Busy) hits++;
    op(F_MFHI, 32'd5, 32'd5);
    if (Done || Busy) hits++;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done || Busy) hits++;
    end
    chk("unsup_quiet", 64'(hits), 64'd0);
    chk("unsup_hilo", {Hi, Lo}, {ohi, olo});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
